// File: rtl/alu_frame_sequencer.sv
// ----------------------------------------------------------------------------
// alu_frame_sequencer
//
// Purpose:
//   Sequences the UART-attached ALU datapath. It pulls a command frame
//   (operand A, operand B, opcode) one byte at a time from the UART RX FIFO
//   and holds the operands stable on the ALU inputs. It then latches the ALU
//   result and pushes that single byte into the UART TX FIFO. A partial frame
//   that stalls longer than TIMEOUT_CYCLES between bytes is dropped, and the
//   drop is reported on o_frame_err.
//
// Optional feature macro:
//   ALU_FRAME_CKSUM_EN - when defined, the frame carries a fourth checksum
//   byte. The checksum must equal A ^ B ^ (full opcode byte). On a mismatch
//   the sequencer sends an all-0xEE error byte instead of a result and pulses
//   o_frame_err. When the macro is undefined, frames are three bytes long.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   i_rx_data    RX FIFO head byte, valid while i_rx_empty=0 (show-ahead)
//   i_rx_empty   RX FIFO empty flag
//   i_tx_full    TX FIFO full flag
//   i_result     combinational ALU result
//   o_rd_uart    RX FIFO pop strobe (one cycle per byte)
//   o_wr_uart    TX FIFO push strobe (one cycle per result)
//   o_tx_data    byte presented to the TX FIFO
//   op_a, op_b   registered ALU operands
//   op_code      registered ALU opcode (low OPCODE_W bits of the opcode byte)
//   o_busy       high whenever a frame is in progress (state other than S_A)
//   o_frame_err  one-cycle pulse on inter-byte timeout or checksum mismatch
// ----------------------------------------------------------------------------
module alu_frame_sequencer #(
  parameter int BUS_SIZE       = 8,
  parameter int OPCODE_W       = 6,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_BITS        = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BUS_SIZE-1:0] i_rx_data,
  input  logic                i_rx_empty,
  input  logic                i_tx_full,
  input  logic [BUS_SIZE-1:0] i_result,
  output logic                o_rd_uart,
  output logic                o_wr_uart,
  output logic [BUS_SIZE-1:0] o_tx_data,
  output logic [BUS_SIZE-1:0] op_a,
  output logic [BUS_SIZE-1:0] op_b,
  output logic [OPCODE_W-1:0] op_code,
  output logic                o_busy,
  output logic                o_frame_err
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
`ifdef ALU_FRAME_CKSUM_EN
    S_CK   = 3'd3,
`endif
    S_EXEC = 3'd4,
    S_SEND = 3'd5
  } state_t;

  // The error byte repeats 0xEE across the bus, truncated to BUS_SIZE bits.
  localparam logic [BUS_SIZE-1:0] ERR_BYTE = BUS_SIZE'({((BUS_SIZE + 7) / 8){8'hEE}});

  state_t             r_state;
  state_t             w_nextState;
  logic [TO_BITS-1:0] r_toCnt;
  logic               w_toState;
  logic               w_capState;
  logic               w_timeout;
  logic               w_pop;

  // The timeout is only armed once a frame has started: S_A can idle forever.
  always_comb begin
    w_toState = (r_state == S_B) || (r_state == S_OP);
`ifdef ALU_FRAME_CKSUM_EN
    if (r_state == S_CK) w_toState = 1'b1;
`endif
  end

  assign w_capState = w_toState || (r_state == S_A);
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && w_toState &&
                      (r_toCnt == TO_BITS'(TIMEOUT_CYCLES));
  // A timeout takes priority over a byte that shows up in the same cycle.
  // That byte stays in the FIFO and becomes byte A of the next frame.
  assign w_pop      = w_capState && !i_rx_empty && !w_timeout;

`ifdef ALU_FRAME_CKSUM_EN
  logic [BUS_SIZE-1:0] r_opByte;
  logic                w_ckOk;
  assign w_ckOk = ((op_a ^ op_b ^ r_opByte) == i_rx_data);
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_A;
    else       r_state <= w_nextState;
  end

  // Next-state logic
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_A:    if (w_pop) w_nextState = S_B;
      S_B: begin
        if (w_timeout)  w_nextState = S_A;
        else if (w_pop) w_nextState = S_OP;
      end
      S_OP: begin
        if (w_timeout) w_nextState = S_A;
`ifdef ALU_FRAME_CKSUM_EN
        else if (w_pop) w_nextState = S_CK;
`else
        else if (w_pop) w_nextState = S_EXEC;
`endif
      end
`ifdef ALU_FRAME_CKSUM_EN
      S_CK: begin
        // A bad checksum skips the ALU and goes straight to sending 0xEE.
        if (w_timeout)  w_nextState = S_A;
        else if (w_pop) w_nextState = w_ckOk ? S_EXEC : S_SEND;
      end
`endif
      S_EXEC: w_nextState = S_SEND;
      S_SEND: if (!i_tx_full) w_nextState = S_A;
      default: w_nextState = S_A;
    endcase
  end

  // Output logic.
  // The pop strobe is gated by reset: S_A with a non-empty FIFO would
  // otherwise raise it while reset is held.
  always_comb begin
    o_rd_uart   = w_pop && !reset;
    o_wr_uart   = (r_state == S_SEND) && !i_tx_full;
    o_busy      = (r_state != S_A);
    o_frame_err = w_timeout;
`ifdef ALU_FRAME_CKSUM_EN
    if ((r_state == S_CK) && w_pop && !w_ckOk) o_frame_err = 1'b1;
`endif
  end

  // Inter-byte timeout counter.
  // It counts empty cycles while a frame is partially received. It restarts
  // on every accepted byte and is held at zero outside the capture states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_toCnt <= '0;
    end else if ((TIMEOUT_CYCLES == 0) || !w_toState || w_pop || w_timeout) begin
      r_toCnt <= '0;
    end else if (i_rx_empty) begin
      r_toCnt <= r_toCnt + 1'b1;
    end
  end

  // Operand capture and result latch.
  // Operands are kept after a timeout, so the ALU inputs only change when
  // a new frame overwrites them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a      <= '0;
      op_b      <= '0;
      op_code   <= '0;
      o_tx_data <= '0;
`ifdef ALU_FRAME_CKSUM_EN
      r_opByte  <= '0;
`endif
    end else begin
      if (w_pop) begin
        case (r_state)
          S_A:  op_a <= i_rx_data;
          S_B:  op_b <= i_rx_data;
          S_OP: begin
            op_code  <= i_rx_data[OPCODE_W-1:0];
`ifdef ALU_FRAME_CKSUM_EN
            r_opByte <= i_rx_data;
`endif
          end
`ifdef ALU_FRAME_CKSUM_EN
          S_CK: if (!w_ckOk) o_tx_data <= ERR_BYTE;
`endif
          default: ;
        endcase
      end
      if (r_state == S_EXEC) o_tx_data <= i_result;
    end
  end

endmodule

// File: tb/tb_alu_frame_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_frame_sequencer
//
// Self-checking bench for alu_frame_sequencer, built with a 16-cycle timeout.
// A frame-level reference model (bytes collected so far, idle count, pending
// ALU step, pending send) predicts every output on every cycle. Directed
// scenarios also pin hand-computed results and latencies. A randomized phase
// mixes byte arrival, TX back-pressure and idle gaps.
// Works with or without ALU_FRAME_CKSUM_EN defined.
// ----------------------------------------------------------------------------
module tb_alu_frame_sequencer;

  localparam int TO = 16;
`ifdef ALU_FRAME_CKSUM_EN
  localparam int FLEN = 4;
`else
  localparam int FLEN = 3;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_rx_empty = 1'b1;
  logic       i_tx_full = 1'b0;
  logic [7:0] i_result;
  logic       o_rd_uart, o_wr_uart, o_busy, o_frame_err;
  logic [7:0] o_tx_data, op_a, op_b;
  logic [5:0] op_code;

  alu_frame_sequencer #(
    .BUS_SIZE(8), .OPCODE_W(6), .TIMEOUT_CYCLES(TO), .TO_BITS(5)
  ) dut (
    .clk(clk), .reset(reset),
    .i_rx_data(i_rx_data), .i_rx_empty(i_rx_empty),
    .i_tx_full(i_tx_full), .i_result(i_result),
    .o_rd_uart(o_rd_uart), .o_wr_uart(o_wr_uart), .o_tx_data(o_tx_data),
    .op_a(op_a), .op_b(op_b), .op_code(op_code),
    .o_busy(o_busy), .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  // Small ALU stub: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR.
  function automatic logic [7:0] aluRef(input logic [7:0] a, input logic [7:0] b,
                                        input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  assign i_result = aluRef(op_a, op_b, op_code);

  // RX FIFO contents as seen by the bench
  logic [7:0] rxQ[$];

  // Frame-level reference model
  int         got, idle;
  logic [7:0] fb[4];
  bit         execP, sendP;
  logic [7:0] mA, mB, mTx;
  logic [5:0] mOp;

  // Observed DUT events
  int         cycle = 0, rdCount = 0, wrCount = 0, errCount = 0, busyCount = 0;
  int         lastRdCyc = 0, lastWrCyc = 0, lastErrCyc = 0;
  logic [7:0] lastWrData = 8'h00;

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, act, exp);
    end
  endtask

  task automatic refreshRx();
    i_rx_empty = (rxQ.size() == 0);
    i_rx_data  = (rxQ.size() == 0) ? 8'h00 : rxQ[0];
  endtask

  task automatic modelReset();
    got = 0; idle = 0; execP = 0; sendP = 0;
    mA = 8'h00; mB = 8'h00; mTx = 8'h00; mOp = 6'h00;
  endtask

  // Push one byte into the RX FIFO
  task automatic applyStimulus(input logic [7:0] b);
    rxQ.push_back(b);
    refreshRx();
  endtask

  task automatic pushFrame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    applyStimulus(a);
    applyStimulus(b);
    applyStimulus(op);
`ifdef ALU_FRAME_CKSUM_EN
    applyStimulus(a ^ b ^ op);
`endif
  endtask

  task automatic checkOutput(input bit eRd, input bit eWr, input bit eErr, input bit eBusy);
    check("o_rd_uart", o_rd_uart, eRd);
    check("o_wr_uart", o_wr_uart, eWr);
    check("o_frame_err", o_frame_err, eErr);
    check("o_busy", o_busy, eBusy);
    check("op_a", op_a, mA);
    check("op_b", op_b, mB);
    check("op_code", op_code, mOp);
    check("o_tx_data", o_tx_data, mTx);
  endtask

  // One clock cycle. Outputs are compared at the falling edge. The model
  // advances at the rising edge, and new FIFO contents appear 1 time unit
  // after it.
  task automatic tick();
    bit         eRd, eWr, eErr, eBusy, fire;
    logic [7:0] popped;
    @(negedge clk);
    cycle++;
    eRd = 0; eWr = 0; eErr = 0; eBusy = 0; fire = 0;
    if (!reset) begin
      if (sendP) begin
        eBusy = 1; eWr = !i_tx_full;
      end else if (execP) begin
        eBusy = 1;
      end else begin
        eBusy = (got > 0);
        fire  = (got > 0) && (idle >= TO);
        eRd   = !i_rx_empty && !fire;
        eErr  = fire;
`ifdef ALU_FRAME_CKSUM_EN
        if (eRd && got == FLEN - 1 && ((fb[0] ^ fb[1] ^ fb[2]) != i_rx_data)) eErr = 1;
`endif
      end
    end
    checkOutput(eRd, eWr, eErr, eBusy);
    if (o_rd_uart === 1'b1) begin rdCount++; lastRdCyc = cycle; end
    if (o_wr_uart === 1'b1) begin wrCount++; lastWrCyc = cycle; lastWrData = o_tx_data; end
    if (o_frame_err === 1'b1) begin errCount++; lastErrCyc = cycle; end
    if (o_busy === 1'b1) busyCount++;
    @(posedge clk);
    if (!reset) begin
      if (sendP) begin
        if (!i_tx_full) sendP = 0;
      end else if (execP) begin
        execP = 0; mTx = aluRef(fb[0], fb[1], fb[2][5:0]); sendP = 1;
      end else if (fire) begin
        got = 0; idle = 0;
      end else if (eRd) begin
        popped = rxQ.pop_front();
        fb[got] = popped;
        if (got == 0) mA = popped;
        if (got == 1) mB = popped;
        if (got == 2) mOp = popped[5:0];
        idle = 0;
        if (got == FLEN - 1) begin
          got = 0; execP = 1;
`ifdef ALU_FRAME_CKSUM_EN
          if ((fb[0] ^ fb[1] ^ fb[2]) != popped) begin
            execP = 0; sendP = 1; mTx = 8'hEE;
          end
`endif
        end else begin
          got++;
        end
      end else if (got > 0) begin
        idle++;
      end
    end
    #1;
    refreshRx();
  endtask

  task automatic runUntilWrite(input string name, input logic [7:0] lit, input int budget);
    int start, n;
    start = wrCount; n = 0;
    while (wrCount == start && n < budget) begin
      tick();
      n++;
    end
    check({name, " write seen"}, (wrCount != start), 1);
    check({name, " data"}, lastWrData, lit);
  endtask

  initial begin
    int wrBefore, errBefore, n, quiet;
    modelReset();
    refreshRx();
    tick();
    check("reset op_a", op_a, 8'h00);
    check("reset o_tx_data", o_tx_data, 8'h00);
    tick();
    reset = 1'b0;
    tick();

    // Back-to-back frame, result exactly two cycles after the last pop
    $display("[TB] scenario: basic ADD frame");
    pushFrame(8'h05, 8'h03, 8'h20);
    rdCount = 0;
    runUntilWrite("add", 8'h08, 20);
    check("add pop count", rdCount, FLEN);
    check("add latency", lastWrCyc - lastRdCyc, 2);

    // TX back-pressure for 50 cycles
    $display("[TB] scenario: TX full stall");
    i_tx_full = 1'b1;
    pushFrame(8'h05, 8'h03, 8'h20);
    repeat (FLEN + 1) tick();
    wrBefore = wrCount; busyCount = 0;
    repeat (50) tick();
    check("stall no write", wrCount, wrBefore);
    check("stall busy cycles", busyCount, 50);
    i_tx_full = 1'b0;
    tick();
    check("stall release write", wrCount, wrBefore + 1);
    check("stall release data", lastWrData, 8'h08);

    // Lone byte times out; the next frame is unaffected
    $display("[TB] scenario: inter-byte timeout");
    wrBefore = wrCount; errBefore = errCount;
    applyStimulus(8'h11);
    n = 0;
    while (errCount == errBefore && n < 40) begin tick(); n++; end
    check("timeout err seen", errCount, errBefore + 1);
    check("timeout err delay", lastErrCyc - lastRdCyc, TO + 1);
    check("timeout no write", wrCount, wrBefore);
    tick();
    check("timeout idle", o_busy, 1'b0);
    pushFrame(8'h0F, 8'h01, 8'h22);
    runUntilWrite("sub", 8'h0E, 20);

    // A byte arriving in the timeout cycle starts the next frame
    $display("[TB] scenario: byte coincident with timeout");
    applyStimulus(8'h33);
    repeat (TO + 1) tick();
    applyStimulus(8'h0F);
    tick();
    tick();
    applyStimulus(8'h01);
    applyStimulus(8'h22);
`ifdef ALU_FRAME_CKSUM_EN
    applyStimulus(8'h0F ^ 8'h01 ^ 8'h22);
`endif
    runUntilWrite("coincident", 8'h0E, 20);

    // Reset in the middle of a frame
    $display("[TB] scenario: reset mid-frame");
    pushFrame(8'h05, 8'h03, 8'h20);
    tick();
    tick();
    reset = 1'b1;
    rxQ.delete();
    modelReset();
    refreshRx();
    tick();
    check("midreset op_a", op_a, 8'h00);
    check("midreset op_b", op_b, 8'h00);
    check("midreset busy", o_busy, 1'b0);
    reset = 1'b0;
    wrBefore = wrCount;
    repeat (5) tick();
    check("midreset no stale write", wrCount, wrBefore);
    pushFrame(8'h0A, 8'h05, 8'h22);
    runUntilWrite("post-reset", 8'h05, 20);
    check("post-reset single write", wrCount, wrBefore + 1);

`ifdef ALU_FRAME_CKSUM_EN
    $display("[TB] scenario: checksum");
    applyStimulus(8'h05); applyStimulus(8'h03); applyStimulus(8'h20); applyStimulus(8'h26);
    runUntilWrite("cksum good", 8'h08, 20);
    errBefore = errCount;
    applyStimulus(8'h05); applyStimulus(8'h03); applyStimulus(8'h20); applyStimulus(8'h27);
    runUntilWrite("cksum bad", 8'hEE, 20);
    check("cksum bad err", errCount, errBefore + 1);
`endif

    // Two frames queued up front
    $display("[TB] scenario: two preloaded frames");
    pushFrame(8'h05, 8'h03, 8'h20);
    pushFrame(8'h0F, 8'h01, 8'h22);
    runUntilWrite("preload first", 8'h08, 20);
    runUntilWrite("preload second", 8'h0E, 20);

    // Randomized traffic with back-pressure and idle gaps
    $display("[TB] scenario: random traffic");
    quiet = 0;
    for (int i = 0; i < 2500; i++) begin
      if (i % 250 == 200) quiet = 30;
      if (quiet > 0) quiet--;
      else if ($urandom_range(99) < 35 && rxQ.size() < 8)
        applyStimulus(8'($urandom_range(255)));
      if ($urandom_range(99) < 6) i_tx_full = ~i_tx_full;
      tick();
    end
    i_tx_full = 1'b0;
    repeat (60) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
